// File: rtl/pll_supervisor_pkg.sv
// pll_supervisor_pkg: shared state encoding, PLL field widths and width helpers
package pll_supervisor_pkg;
  typedef enum logic [2:0] {
    S_OFF,
    S_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;
  localparam int DIVR_W   = 4;
  localparam int DIVF_W   = 7;
  localparam int DIVQ_W   = 3;
  localparam int FILTER_W = 3;
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/pll_core.sv
// pll_core: SB_PLL40_CORE wrapper (SIMPLE feedback, no bypass); behavioural lock model outside synthesis
module pll_core
  import pll_supervisor_pkg::*;
#(
  parameter int DIVR         = 4,
  parameter int DIVF         = 31,
  parameter int DIVQ         = 4,
  parameter int FILTER_RANGE = 2,
  parameter int LOCK_DELAY   = 10
) (
  input  logic REFERENCECLK,
  input  logic RESETB,
  output logic LOCK,
  output logic PLLOUTCORE
);
  if (DIVR < 0 || DIVR >= (1 << DIVR_W) || DIVF < 0 || DIVF >= (1 << DIVF_W) ||
      DIVQ < 0 || DIVQ >= (1 << DIVQ_W) || FILTER_RANGE < 0 || FILTER_RANGE >= (1 << FILTER_W) ||
      LOCK_DELAY < 1) begin : g_bad_cfg
    $error("pll_core: PLL setting out of range");
  end
`ifdef SYNTHESIS
  SB_PLL40_CORE #(
    .FEEDBACK_PATH("SIMPLE"),
    .DIVR(DIVR_W'(DIVR)),
    .DIVF(DIVF_W'(DIVF)),
    .DIVQ(DIVQ_W'(DIVQ)),
    .FILTER_RANGE(FILTER_W'(FILTER_RANGE))
  ) u_pll (
    .REFERENCECLK(REFERENCECLK),
    .RESETB(RESETB),
    .BYPASS(1'b0),
    .LOCK(LOCK),
    .PLLOUTCORE(PLLOUTCORE),
    .PLLOUTGLOBAL(),
    .EXTFEEDBACK(1'b0),
    .DYNAMICDELAY(8'd0),
    .LATCHINPUTVALUE(1'b0),
    .SCLK(1'b0),
    .SDI(1'b0),
    .SDO()
  );
`else
  localparam int DW = cnt_w(LOCK_DELAY);
  logic [DW-1:0] r_cnt;
  logic          r_lock;
  // lock asserts LOCK_DELAY reference cycles after RESETB is released
  always_ff @(posedge REFERENCECLK) begin
    r_cnt  <= !RESETB ? '0 : r_cnt + DW'(r_cnt != DW'(LOCK_DELAY));
    r_lock <= RESETB && (r_cnt >= DW'(LOCK_DELAY - 1));
  end
  assign LOCK       = r_lock;
  assign PLLOUTCORE = REFERENCECLK & RESETB;
`endif
endmodule

// File: rtl/pll_supervisor.sv
// pll_supervisor: PLL reset/lock sequencer with debounce, retry and relock recovery (option PLL_RELOCK_COUNT_EN)
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int DIVR                = 4,
  parameter int DIVF                = 31,
  parameter int DIVQ                = 4,
  parameter int FILTER_RANGE        = 2,
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 8
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  output logic             clock_out,
  output logic             locked,
  output logic             ready,
  output logic             fault,
  output logic [CNT_W-1:0] relock_count
);
  localparam int TMR_W = cnt_w(max3(RESET_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES));
  localparam int RTY_W = cnt_w(MAX_RETRIES);
  state_t           r_state, w_state_nx;
  logic [TMR_W-1:0] r_tmr, w_tmr_nx;
  logic [RTY_W-1:0] r_rty, w_rty_nx;
  logic             r_sync1, r_sync2, r_resetb, r_ready, r_fault;
  logic             w_pll_lock;
  pll_core #(
    .DIVR(DIVR),
    .DIVF(DIVF),
    .DIVQ(DIVQ),
    .FILTER_RANGE(FILTER_RANGE)
  ) u_core (
    .REFERENCECLK(clock_in),
    .RESETB(r_resetb),
    .LOCK(w_pll_lock),
    .PLLOUTCORE(clock_out)
  );
  // two-flop synchroniser for the asynchronous PLL LOCK
  always_ff @(posedge clock_in) begin
    r_sync1 <= reset ? 1'b0 : w_pll_lock;
    r_sync2 <= reset ? 1'b0 : r_sync1;
  end
  // next state; one timer serves as reset pulse, lock timeout and stable count
  always_comb begin
    w_state_nx = r_state;
    w_tmr_nx   = r_tmr;
    w_rty_nx   = r_rty;
    if (!enable) begin
      w_state_nx = S_OFF;
      w_tmr_nx   = '0;
      w_rty_nx   = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nx = S_RST;
          w_tmr_nx   = '0;
        end
        S_RST: begin
          w_state_nx = (r_tmr == TMR_W'(RESET_PULSE_CYCLES - 1)) ? S_WAIT_LOCK : S_RST;
          w_tmr_nx   = (r_tmr == TMR_W'(RESET_PULSE_CYCLES - 1)) ? '0 : r_tmr + TMR_W'(1);
        end
        S_WAIT_LOCK: begin
          if (r_sync2) begin
            w_state_nx = S_STABLE;
            w_tmr_nx   = '0;
          end else if (r_tmr == TMR_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            w_tmr_nx   = '0;
            w_state_nx = (r_rty < RTY_W'(MAX_RETRIES)) ? S_RST : S_FAULT;
            w_rty_nx   = (r_rty < RTY_W'(MAX_RETRIES)) ? r_rty + RTY_W'(1) : r_rty;
          end else begin
            w_tmr_nx = r_tmr + TMR_W'(1);
          end
        end
        S_STABLE: begin
          if (!r_sync2) begin
            w_state_nx = S_WAIT_LOCK;
            w_tmr_nx   = '0;
          end else if (r_tmr == TMR_W'(LOCK_STABLE_CYCLES - 1)) begin
            w_state_nx = S_RUN;
            w_tmr_nx   = '0;
            w_rty_nx   = '0;
          end else begin
            w_tmr_nx = r_tmr + TMR_W'(1);
          end
        end
        S_RUN: begin
          w_state_nx = r_sync2 ? S_RUN : S_RST;
          w_tmr_nx   = '0;
        end
        S_FAULT: w_state_nx = S_FAULT;
        default: w_state_nx = S_OFF;
      endcase
    end
  end
  // state and registered outputs derived from the next state
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state  <= S_OFF;
      r_tmr    <= '0;
      r_rty    <= '0;
      r_resetb <= 1'b0;
      r_ready  <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_tmr    <= w_tmr_nx;
      r_rty    <= w_rty_nx;
      r_resetb <= (w_state_nx == S_WAIT_LOCK) || (w_state_nx == S_STABLE) || (w_state_nx == S_RUN);
      r_ready  <= (w_state_nx == S_RUN);
      r_fault  <= (w_state_nx == S_FAULT);
    end
  end
`ifdef PLL_RELOCK_COUNT_EN
  logic [CNT_W-1:0] r_relock;
  // count lock losses in RUN, saturating
  always_ff @(posedge clock_in) begin
    if (reset) r_relock <= '0;
    else if (r_state == S_RUN && w_state_nx == S_RST && r_relock != '1) r_relock <= r_relock + CNT_W'(1);
  end
  assign relock_count = r_relock;
`else
  assign relock_count = '0;
`endif
  assign locked = r_sync2;
  assign ready  = r_ready;
  assign fault  = r_fault;
endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor: directed checks of lock sequencing, debounce, relock, timeout/fault and reset
module tb_pll_supervisor;
`ifdef PLL_RELOCK_COUNT_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif
  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       clock_out, locked, ready, fault;
  logic [1:0] relock_count;
  int         checks = 0;
  int         failures = 0;
  always #5 clock_in = ~clock_in;
  pll_supervisor #(
    .RESET_PULSE_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(2),
    .CNT_W(2)
  ) dut (
    .clock_in(clock_in),
    .reset(reset),
    .enable(enable),
    .clock_out(clock_out),
    .locked(locked),
    .ready(ready),
    .fault(fault),
    .relock_count(relock_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask
  function automatic int exp_rc(input int n);
    return RC_EN ? ((n > 3) ? 3 : n) : 0;
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    // 1: reset state, first lock, ready latency
    tick(2);
    check("rst_ready", ready, 0);
    check("rst_fault", fault, 0);
    check("rst_locked", locked, 0);
    check("rst_relock", relock_count, 0);
    check("rst_resetb", dut.r_resetb, 0);
    reset = 1'b0;
    enable = 1'b1;
    tick(1);
    check("s1_resetb_a0", dut.r_resetb, 0);
    tick(3);
    check("s1_resetb_a3", dut.r_resetb, 0);
    tick(1);
    check("s1_resetb_a4", dut.r_resetb, 1);
    tick(11);
    check("s1_locked_a15", locked, 0);
    tick(1);
    check("s1_locked_a16", locked, 1);
    tick(8);
    check("s1_ready_a24", ready, 0);
    tick(1);
    check("s1_ready_a25", ready, 1);
    check("s1_relock", relock_count, 0);
    // leave RUN via enable=0, then 2: single-cycle lock glitch during STABLE
    enable = 1'b0;
    tick(1);
    check("s2_off_ready", ready, 0);
    check("s2_off_resetb", dut.r_resetb, 0);
    enable = 1'b1;
    tick(5);
    check("s2_resetb_b5", dut.r_resetb, 1);
    tick(16);
    force dut.w_pll_lock = 1'b0;
    tick(1);
    release dut.w_pll_lock;
    tick(1);
    check("s2_locked_glitch", locked, 0);
    check("s2_ready_glitch", ready, 0);
    tick(9);
    check("s2_ready_b32", ready, 0);
    tick(1);
    check("s2_ready_b33", ready, 1);
    // 3: lock loss in RUN, relock counting and saturation
    for (int i = 1; i <= 4; i++) begin
      force dut.w_pll_lock = 1'b0;
      tick(2);
      check("s3_ready_c2", ready, 1);
      tick(1);
      check("s3_ready_c3", ready, 0);
      check("s3_resetb_c3", dut.r_resetb, 0);
      check("s3_relock", relock_count, exp_rc(i));
      tick(1);
      release dut.w_pll_lock;
      tick(2);
      check("s3_resetb_c6", dut.r_resetb, 0);
      tick(1);
      check("s3_resetb_c7", dut.r_resetb, 1);
      tick(20);
      check("s3_ready_c27", ready, 0);
      tick(1);
      check("s3_ready_c28", ready, 1);
    end
    // 5a: enable=0 while in STABLE
    force dut.w_pll_lock = 1'b0;
    tick(4);
    release dut.w_pll_lock;
    tick(18);
    check("s5_stable_ready", ready, 0);
    check("s5_stable_resetb", dut.r_resetb, 1);
    enable = 1'b0;
    tick(1);
    check("s5_off_resetb", dut.r_resetb, 0);
    check("s5_off_ready", ready, 0);
    check("s5_off_relock_kept", relock_count, exp_rc(5));
    // 5b: reset in RUN
    enable = 1'b1;
    tick(26);
    check("s5_run_ready", ready, 1);
    reset = 1'b1;
    tick(1);
    check("s5_rst_ready", ready, 0);
    check("s5_rst_fault", fault, 0);
    check("s5_rst_locked", locked, 0);
    check("s5_rst_relock", relock_count, 0);
    check("s5_rst_resetb", dut.r_resetb, 0);
    // 4: PLL never locks -> three attempts then fault
    force dut.w_pll_lock = 1'b0;
    reset = 1'b0;
    tick(5);
    check("s4_resetb_a4", dut.r_resetb, 1);
    tick(31);
    check("s4_resetb_a35", dut.r_resetb, 1);
    tick(1);
    check("s4_resetb_a36", dut.r_resetb, 0);
    tick(4);
    check("s4_resetb_a40", dut.r_resetb, 1);
    tick(67);
    check("s4_fault_a107", fault, 0);
    check("s4_resetb_a107", dut.r_resetb, 1);
    tick(1);
    check("s4_fault_a108", fault, 1);
    check("s4_ready_a108", ready, 0);
    check("s4_resetb_a108", dut.r_resetb, 0);
    tick(5);
    check("s4_fault_sticky", fault, 1);
    check("s4_locked", locked, 0);
    enable = 1'b0;
    tick(1);
    check("s4_fault_clr", fault, 0);
    enable = 1'b1;
    tick(1);
    check("s4_retry_resetb0", dut.r_resetb, 0);
    check("s4_retry_fault", fault, 0);
    tick(3);
    check("s4_retry_resetb3", dut.r_resetb, 0);
    tick(1);
    check("s4_retry_resetb4", dut.r_resetb, 1);
    release dut.w_pll_lock;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
